// File: rtl/apb_reg_responder_pkg.sv
// Shared types and constants for the APB register responder and its register bank.
package apb_reg_responder_pkg;

    localparam int LANE_W      = 8;
    localparam int WORD_OFFSET = 2;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_DONE   = 2'd2
    } state_e;

endpackage

// File: rtl/apb_reg_bank.sv
// Word register array with per-byte write strobes and an indexed read port.
module apb_reg_bank
    import apb_reg_responder_pkg::*;
#(
    parameter int                    DATA_WIDTH = 32,
    parameter int                    NUM_REGS   = 16,
    parameter int                    IDX_W      = 10,
    parameter logic [DATA_WIDTH-1:0] RESET_VAL  = '0
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           wr_en,
    input  logic [IDX_W-1:0]               wr_idx,
    input  logic [DATA_WIDTH-1:0]          wr_data,
    input  logic [DATA_WIDTH/LANE_W-1:0]   wr_strb,
    input  logic [IDX_W-1:0]               rd_idx,
    output logic [DATA_WIDTH-1:0]          rd_data,
    output logic [NUM_REGS*DATA_WIDTH-1:0] regs_flat
);

    localparam int STRB_W = DATA_WIDTH / LANE_W;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_REGS; gi++) begin : g_reg
            logic [DATA_WIDTH-1:0] word_reg;
            logic                  hit;

            assign hit = wr_en && (wr_idx == IDX_W'(gi));

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    word_reg <= RESET_VAL;
                end else if (hit) begin
                    for (int b = 0; b < STRB_W; b++) begin
                        if (wr_strb[b]) begin
                            word_reg[b*LANE_W +: LANE_W] <= wr_data[b*LANE_W +: LANE_W];
                        end
                    end
                end
            end

            assign regs_flat[gi*DATA_WIDTH +: DATA_WIDTH] = word_reg;
        end
    endgenerate

    // Out-of-range indices read as zero; the top never uses them anyway.
    always_comb begin
        rd_data = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (rd_idx == IDX_W'(i)) begin
                rd_data = regs_flat[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

endmodule

// File: rtl/apb_reg_responder.sv
// APB slave exposing NUM_REGS word registers with programmable wait states.
// Optional privilege check on writes enabled by APB_REG_RESPONDER_PROT_EN.
module apb_reg_responder
    import apb_reg_responder_pkg::*;
#(
    parameter int                    ADDR_WIDTH  = 12,
    parameter int                    DATA_WIDTH  = 32,
    parameter int                    NUM_REGS    = 16,
    parameter int                    WAIT_CYCLES = 0,
    parameter logic [DATA_WIDTH-1:0] RESET_VAL   = '0
) (
    input  logic                           clk_i,
    input  logic                           rst_ni,
    input  logic                           psel_i,
    input  logic                           penable_i,
    input  logic                           pwrite_i,
    input  logic [ADDR_WIDTH-1:0]          paddr_i,
    input  logic [DATA_WIDTH-1:0]          pwdata_i,
    input  logic [DATA_WIDTH/8-1:0]        pstrb_i,
`ifdef APB_REG_RESPONDER_PROT_EN
    input  logic [2:0]                     pprot_i,
`endif
    output logic [DATA_WIDTH-1:0]          prdata_o,
    output logic                           pready_o,
    output logic                           pslverr_o,
    output logic [NUM_REGS*DATA_WIDTH-1:0] regs_o
);

    localparam int         IDX_W     = ADDR_WIDTH - WORD_OFFSET;
    localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);

    state_e               state_reg, state_next;
    logic [3:0]           wait_cnt_reg, wait_cnt_next;
    logic [IDX_W-1:0]     word_idx;
    logic                 addr_err, prot_err, xfer_err;
    logic                 complete, wr_en;
    logic [DATA_WIDTH-1:0] rd_data;

    assign word_idx = paddr_i[ADDR_WIDTH-1:WORD_OFFSET];
    assign addr_err = (paddr_i[WORD_OFFSET-1:0] != '0)
                   || ({1'b0, word_idx} >= (IDX_W+1)'(NUM_REGS));

`ifdef APB_REG_RESPONDER_PROT_EN
    assign prot_err = pwrite_i && !pprot_i[0];
`else
    assign prot_err = 1'b0;
`endif

    assign xfer_err = addr_err || prot_err;

    // The completing access cycle is the one where the wait budget is spent.
    assign complete = (state_reg == ST_ACCESS) && psel_i && penable_i && (wait_cnt_reg == '0);
    assign wr_en    = complete && pwrite_i && !xfer_err;

    assign pready_o  = complete;
    assign pslverr_o = complete && xfer_err;
    assign prdata_o  = (complete && !pwrite_i && !xfer_err) ? rd_data : '0;

    always_comb begin
        state_next    = state_reg;
        wait_cnt_next = wait_cnt_reg;
        case (state_reg)
            ST_IDLE: begin
                if (psel_i && !penable_i) begin
                    state_next    = ST_ACCESS;
                    wait_cnt_next = WAIT_INIT;
                end
            end
            ST_ACCESS: begin
                if (!psel_i) begin
                    state_next    = ST_IDLE;
                    wait_cnt_next = '0;
                end else if (complete) begin
                    state_next = ST_DONE;
                end else if (wait_cnt_reg != '0) begin
                    wait_cnt_next = wait_cnt_reg - 4'd1;
                end
            end
            ST_DONE: begin
                state_next = ST_IDLE;
            end
            default: begin
                state_next    = ST_IDLE;
                wait_cnt_next = '0;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_reg    <= ST_IDLE;
            wait_cnt_reg <= '0;
        end else begin
            state_reg    <= state_next;
            wait_cnt_reg <= wait_cnt_next;
        end
    end

    apb_reg_bank #(
        .DATA_WIDTH (DATA_WIDTH),
        .NUM_REGS   (NUM_REGS),
        .IDX_W      (IDX_W),
        .RESET_VAL  (RESET_VAL)
    ) u_bank (
        .clk       (clk_i),
        .rst_n     (rst_ni),
        .wr_en     (wr_en),
        .wr_idx    (word_idx),
        .wr_data   (pwdata_i),
        .wr_strb   (pstrb_i),
        .rd_idx    (word_idx),
        .rd_data   (rd_data),
        .regs_flat (regs_o)
    );

endmodule
